// File: rtl/board_pkg.sv
// Shared board geometry and the cell painter's state type.
package board_pkg;

    localparam int WIDTH     = 10;
    localparam int SPACING   = 2;
    localparam int PITCH     = WIDTH + SPACING;
    localparam int GRID_DIM  = 16;
    localparam int NUM_CELLS = GRID_DIM * GRID_DIM;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        DRAW,
        DONE
    } painterState_t;

    // Pixel origin of grid index idx along one axis.
    function automatic logic [9:0] gridOrigin(input logic [3:0] idx, input int pitch);
        return 10'(int'(idx) * pitch);
    endfunction

endpackage

// File: rtl/cell_tile_painter_tile_scan.sv
// Row-major scan counter over a WIDTH x WIDTH square.
// Exposes the coordinate the counter will hold after a step, so callers can
// register a pixel position in the same edge that advances the scan.
module tile_scan
    import board_pkg::*;
#(
    parameter int WIDTH = board_pkg::WIDTH,
    localparam int CW   = $clog2(WIDTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          step,
    output logic [CW-1:0] col,
    output logic [CW-1:0] row,
    output logic [CW-1:0] nextCol,
    output logic [CW-1:0] nextRow,
    output logic          last
);

    localparam logic [CW-1:0] MAX_IDX = CW'(WIDTH - 1);

    // Successor coordinate: column wraps into the next row, last row wraps to 0.
    always_comb begin
        nextCol = (col == MAX_IDX) ? '0 : col + CW'(1);
        nextRow = row;
        if (col == MAX_IDX) begin
            nextRow = (row == MAX_IDX) ? '0 : row + CW'(1);
        end
        last = (col == MAX_IDX) && (row == MAX_IDX);
    end

    // Counter register: clear has priority over step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            col <= nextCol;
            row <= nextRow;
        end
    end

endmodule

// File: rtl/cell_tile_painter.sv
// Paints one board cell as a filled square on the VGA framebuffer:
// fetch the cell value from BRAM, map it to a colour, emit WIDTH*WIDTH
// plots row-major at the cell's grid position, then pulse done.
module cell_tile_painter
    import board_pkg::*;
#(
    parameter int                     WIDTH                 = board_pkg::WIDTH,
    parameter int                     SPACING               = board_pkg::SPACING,
    parameter int                     COLOUR_BITS           = 3,
    parameter logic [COLOUR_BITS-1:0] BG_COLOUR             = '0,
    parameter bit                     EMPTY_COLOUR_OVERRIDE = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [8:0]             address,
    input  logic [COLOUR_BITS-1:0] cell_q,
    output logic                   rden,
    output logic [8:0]             bram_addr,
    output logic [9:0]             vga_x,
    output logic [8:0]             vga_y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    localparam int PITCH_PX = WIDTH + SPACING;
    localparam int CW       = $clog2(WIDTH);

    painterState_t          state, stateNext;
    logic [7:0]             addrR, addrNext;
    logic [COLOUR_BITS-1:0] colR, colRNext;
    logic [COLOUR_BITS-1:0] mappedColour;
    logic [9:0]             originX;
    logic [8:0]             originY;

    logic                   rdenNext, plotNext, doneNext, busyNext;
    logic [8:0]             bramAddrNext;
    logic [9:0]             xNext;
    logic [8:0]             yNext;
    logic [COLOUR_BITS-1:0] colourNext;

    logic                   scanClear, scanStep, scanLast;
    logic [CW-1:0]          scanCol, scanRow, scanNextCol, scanNextRow;

    tile_scan #(.WIDTH(WIDTH)) scan (
        .clock   (clock),
        .reset   (reset),
        .clear   (scanClear),
        .step    (scanStep),
        .col     (scanCol),
        .row     (scanRow),
        .nextCol (scanNextCol),
        .nextRow (scanNextRow),
        .last    (scanLast)
    );

    // Empty cells may be drawn in the background colour instead of raw 0.
    assign mappedColour = (EMPTY_COLOUR_OVERRIDE && cell_q == '0) ? BG_COLOUR : cell_q;
    assign originX      = gridOrigin(addrR[3:0], PITCH_PX);
    assign originY      = 9'(gridOrigin(addrR[7:4], PITCH_PX));

    // Next-state and next-output logic; outputs are computed one edge ahead so
    // every port comes straight from a register.
    always_comb begin
        stateNext    = state;
        addrNext     = addrR;
        colRNext     = colR;
        rdenNext     = 1'b0;
        plotNext     = 1'b0;
        doneNext     = 1'b0;
        bramAddrNext = bram_addr;
        xNext        = vga_x;
        yNext        = vga_y;
        colourNext   = colour;
        scanClear    = 1'b0;
        scanStep     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    addrNext = address[7:0];
                    if (!address[8]) begin
                        stateNext    = FETCH;
                        rdenNext     = 1'b1;
                        bramAddrNext = address;
                    end else begin
                        // Off-board address: nothing to draw, just acknowledge.
                        stateNext = DONE;
                        doneNext  = 1'b1;
                    end
                end
            end
            FETCH: stateNext = WAIT;
            WAIT: begin
                colRNext   = mappedColour;
                colourNext = mappedColour;
                scanClear  = 1'b1;
                plotNext   = 1'b1;
                xNext      = originX;
                yNext      = originY;
                stateNext  = DRAW;
            end
            DRAW: begin
                if (scanLast) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                end else begin
                    scanStep   = 1'b1;
                    plotNext   = 1'b1;
                    xNext      = originX + 10'(scanNextCol);
                    yNext      = originY + 9'(scanNextRow);
                    colourNext = colR;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        busyNext = (stateNext != IDLE);
    end

    // State and output registers; reset aborts any cell in progress silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addrR     <= '0;
            colR      <= '0;
            rden      <= 1'b0;
            bram_addr <= '0;
            vga_x     <= '0;
            vga_y     <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= stateNext;
            addrR     <= addrNext;
            colR      <= colRNext;
            rden      <= rdenNext;
            bram_addr <= bramAddrNext;
            vga_x     <= xNext;
            vga_y     <= yNext;
            colour    <= colourNext;
            plot      <= plotNext;
            busy      <= busyNext;
            done      <= doneNext;
        end
    end

endmodule

// File: tb/tb_cell_tile_painter.sv
// Scoreboard bench for cell_tile_painter: the driver queues the expected
// reads, pixels and done pulses per cell; a negedge monitor checks them.
module tb_cell_tile_painter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] address = '0;
    logic [2:0] cell_q = '0;
    logic       rden, plot, busy, done;
    logic [8:0] bram_addr;
    logic [9:0] vga_x;
    logic [8:0] vga_y;
    logic [2:0] colour;

    always #5 clock = ~clock;

    cell_tile_painter #(.BG_COLOUR(3'b111)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .address   (address),
        .cell_q    (cell_q),
        .rden      (rden),
        .bram_addr (bram_addr),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    // Board memory with one-cycle read latency.
    logic [2:0] mem [256];
    always @(posedge clock) if (rden) cell_q <= mem[bram_addr[7:0]];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int cyc; int x; int y; int c; } pix_t;
    typedef struct { int cyc; int a; } rd_t;
    pix_t pixQ[$];
    rd_t  rdQ[$];
    int   doneQ[$];

    int total = 0, bad = 0, plotCount = 0, doneCount = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int expColour(input int v);
        return (v == 0) ? 7 : v;
    endfunction

    // Expected behaviour of one request issued in cycle k.
    task automatic pushExpect(input int a, input int k);
        int c;
        if (a < 256) begin
            rdQ.push_back('{k + 1, a});
            c = expColour(int'(mem[a]));
            for (int r = 0; r < 10; r++)
                for (int cc = 0; cc < 10; cc++)
                    pixQ.push_back('{k + 3 + r * 10 + cc, 12 * (a % 16) + cc, 12 * (a / 16) + r, c});
            doneQ.push_back(k + 103);
        end else begin
            doneQ.push_back(k + 1);
        end
    endtask

    // Monitor: every strobe from the DUT must match the head of its queue.
    always @(negedge clock) begin
        pix_t p;
        rd_t  q;
        int   dc;
        if (plot) begin
            plotCount++;
            if (pixQ.size() == 0) check("unexpected_plot", int'(plot), 0);
            else begin
                p = pixQ.pop_front();
                check("plot_cycle", cyc, p.cyc);
                check("plot_x", int'(vga_x), p.x);
                check("plot_y", int'(vga_y), p.y);
                check("plot_colour", int'(colour), p.c);
            end
        end
        if (rden) begin
            if (rdQ.size() == 0) check("unexpected_rden", int'(rden), 0);
            else begin
                q = rdQ.pop_front();
                check("rden_cycle", cyc, q.cyc);
                check("bram_addr", int'(bram_addr), q.a);
            end
        end
        if (done) begin
            doneCount++;
            if (doneQ.size() == 0) check("unexpected_done", int'(done), 0);
            else begin
                dc = doneQ.pop_front();
                check("done_cycle", cyc, dc);
            end
        end
    end

    task automatic paint(input int a);
        int k, d0;
        @(negedge clock);
        check("busy_idle", int'(busy), 0);
        d0 = doneCount;
        k = cyc;
        start = 1'b1;
        address = a[8:0];
        pushExpect(a, k);
        @(negedge clock);
        start = 1'b0;
        address = 9'($urandom_range(0, 511));
        check("busy_run", int'(busy), 1);
        for (int n = 0; n < 200 && doneCount == d0; n++) begin
            @(negedge clock);
            #1;
        end
        check("done_seen", doneCount - d0, 1);
        $display("cell addr=%0d started cycle %0d, plots so far=%0d", a, k, plotCount);
    endtask

    initial begin
        int k, d0, p0;
        for (int i = 0; i < 256; i++) mem[i] = 3'($urandom_range(0, 7));

        repeat (3) @(negedge clock);
        check("rst_plot", int'(plot), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_rden", int'(rden), 0);
        check("rst_xyc", int'(vga_x) + int'(vga_y) + int'(colour) + int'(bram_addr), 0);
        reset = 1'b0;

        mem[0] = 3'b101;   paint(0);
        mem[255] = 3'b010; paint(255);
        mem[17] = 3'b000;  paint(17);
        paint(256);
        repeat (6) paint(int'($urandom_range(0, 511)));

        // Abort mid-draw: a second start is ignored, reset drops everything.
        @(negedge clock);
        d0 = doneCount;
        k = cyc;
        start = 1'b1;
        address = 9'd53;
        pushExpect(53, k);
        @(negedge clock);
        start = 1'b0;
        while (cyc < k + 20) @(negedge clock);
        start = 1'b1;
        address = 9'($urandom_range(0, 255));
        @(negedge clock);
        start = 1'b0;
        while (cyc < k + 43) @(negedge clock);
        #1;
        reset = 1'b1;
        pixQ.delete();
        rdQ.delete();
        doneQ.delete();
        #1;
        check("abort_plot", int'(plot), 0);
        check("abort_done", int'(done), 0);
        check("abort_busy", int'(busy), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (120) @(negedge clock);
        #1;
        check("abort_no_done", doneCount - d0, 0);
        $display("abort sequence finished at cycle %0d", cyc);
        paint(int'($urandom_range(0, 255)));

        // Full board, back to back, as driven by the address counter.
        d0 = doneCount;
        p0 = plotCount;
        for (int a = 0; a < 256; a++) paint(a);
        check("board_plots", plotCount - p0, 25600);
        check("board_doneAll", doneCount - d0, 256);
        check("queues_empty", pixQ.size() + rdQ.size() + doneQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
